writeback_regfile: RTL and testbench

//   Register-writeback (RW) stage of the simpleRISC core; sits directly downstream of memory access.

---
 rtl/writeback_regfile.sv | 86 ++++++++
 tb/tb_writeback_regfile.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Register-writeback stage of the simpleRISC core: selects the writeback value, holds it for one
// cycle in the RW latch, then commits it to the register file. Optional macro: WB_BYPASS_EN.
module writeback_regfile #(
    parameter int              DATA_W   = 32,
    parameter int              NUM_REGS = 16,
    parameter int              ADDR_W   = 4,
    parameter logic [DATA_W-1:0] SP_INIT = 32'd31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] ldResult,
    input  logic [ADDR_W-1:0] rd,
    input  logic              isWb,
    input  logic              isLd,
    input  logic              isCall,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       retire_cnt
);

    localparam int              SP_IDX = NUM_REGS - 2;
    localparam logic [ADDR_W-1:0] RA_IDX = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              capture;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // A call links pc+4 into ra and overrides any other writeback selection.
    always_comb begin
        capture  = in_valid && !flush;
        sel_addr = rd;
        sel_data = aluResult;
        if (isCall) begin
            sel_addr = RA_IDX;
            sel_data = pc + DATA_W'(4);
        end else if (isLd) begin
            sel_data = ldResult;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            retire_cnt <= '0;
        end else if (capture) begin
            wb_valid   <= isWb || isCall;
            wb_addr    <= sel_addr;
            wb_data    <= sel_data;
            retire_cnt <= retire_cnt + 32'd1;
        end else begin
            wb_valid   <= 1'b0;
        end
    end

    // Reset drops whatever sits in the RW latch, so nothing is committed on the reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wb_valid) begin
            regs[wb_addr] <= wb_data;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs1_data = (wb_valid && (rs1_addr == wb_addr)) ? wb_data : regs[rs1_addr];
    assign rs2_data = (wb_valid && (rs2_addr == wb_addr)) ? wb_data : regs[rs2_addr];
`else
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: stimulus pushes expected RW-latch writes, a monitor
// pops them whenever wb_valid is seen; register reads and retire count are checked directly.
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] ld_result;
    logic [3:0]  rd;
    logic        is_wb;
    logic        is_ld;
    logic        is_call;
    logic [3:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic [3:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] retire_cnt;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t     exp_q[$];
    int          pass_cnt;
    int          total_cnt;
    logic [31:0] retire_exp;

    writeback_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .flush     (flush),
        .pc        (pc),
        .aluResult (alu_result),
        .ldResult  (ld_result),
        .rd        (rd),
        .isWb      (is_wb),
        .isLd      (is_ld),
        .isCall    (is_call),
        .rs1_addr  (rs1_addr),
        .rs1_data  (rs1_data),
        .rs2_addr  (rs2_addr),
        .rs2_data  (rs2_data),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drives one MA-stage slot at the falling edge; the next rising edge captures it.
    task automatic applyStimulus(input logic v, input logic f, input logic [31:0] pc_i,
                                 input logic [31:0] alu_i, input logic [31:0] ld_i,
                                 input logic [3:0] rd_i, input logic wb_i, input logic ld_i_flag,
                                 input logic call_i);
        wb_exp_t e;
        @(negedge clk);
        in_valid   = v;
        flush      = f;
        pc         = pc_i;
        alu_result = alu_i;
        ld_result  = ld_i;
        rd         = rd_i;
        is_wb      = wb_i;
        is_ld      = ld_i_flag;
        is_call    = call_i;
        if (v && !f) begin
            retire_exp = retire_exp + 32'd1;
            if (wb_i || call_i) begin
                e.addr = call_i ? 4'd15 : rd_i;
                e.data = call_i ? pc_i + 32'd4 : (ld_i_flag ? ld_i : alu_i);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic readCheck(input string name, input logic [3:0] addr, input logic [31:0] expected);
        rs1_addr = addr;
        rs2_addr = addr;
        #1;
        checkOutput({name, "_rs1"}, rs1_data, expected);
        checkOutput({name, "_rs2"}, rs2_data, expected);
    endtask

    // Monitor: every pending write the DUT presents must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_wb_valid", {31'd0, wb_valid}, 32'd0);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                checkOutput("wb_addr", {28'd0, wb_addr}, {28'd0, e.addr});
                checkOutput("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        retire_exp = 32'd0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        pc         = '0;
        alu_result = '0;
        ld_result  = '0;
        rd         = '0;
        is_wb      = 1'b0;
        is_ld      = 1'b0;
        is_call    = 1'b0;
        rs1_addr   = '0;
        rs2_addr   = '0;
        #12 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("rst_retire", retire_cnt, 32'd0);
        for (int i = 0; i < 16; i++) begin
            readCheck($sformatf("rst_r%0d", i), 4'(i), (i == 14) ? 32'd31 : 32'd0);
        end

        // ALU writeback to r3
        applyStimulus(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0);
        idleCycle();
`ifdef WB_BYPASS_EN
        readCheck("alu_r3_early", 4'd3, 32'hDEADBEEF);
`else
        readCheck("alu_r3_early", 4'd3, 32'h0);
`endif
        idleCycle();
        readCheck("alu_r3", 4'd3, 32'hDEADBEEF);

        // Load selects ldResult over aluResult
        applyStimulus(1'b1, 1'b0, 32'h14, 32'h12345678, 32'hFFFFFFE3, 4'd5, 1'b1, 1'b1, 1'b0);
        idleCycle();
        idleCycle();
        readCheck("ld_r5", 4'd5, 32'hFFFFFFE3);

        // Call overrides rd, isWb and isLd
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h99, 32'h77, 4'd7, 1'b1, 1'b1, 1'b1);
        idleCycle();
        idleCycle();
        readCheck("call_r15", 4'd15, 32'h44);
        readCheck("call_r7", 4'd7, 32'h0);

        // Flush squashes the write and the retire
        applyStimulus(1'b1, 1'b1, 32'h50, 32'hAAAA5555, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        readCheck("flush_r2", 4'd2, 32'h0);
        checkOutput("flush_retire", retire_cnt, retire_exp);

        // Non-writing instruction still retires; r0 is writable
        applyStimulus(1'b1, 1'b0, 32'h54, 32'hBADBAD00, 32'h0, 4'd6, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h58, 32'h00000055, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        readCheck("nowb_r6", 4'd6, 32'h0);
        readCheck("r0_write", 4'd0, 32'h55);
        checkOutput("retire_cnt", retire_cnt, retire_exp);

        // Back-to-back writes to r4
        applyStimulus(1'b1, 1'b0, 32'h60, 32'h1, 32'h0, 4'd4, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h64, 32'h2, 32'h0, 4'd4, 1'b1, 1'b0, 1'b0);
`ifdef WB_BYPASS_EN
        readCheck("b2b_r4_a", 4'd4, 32'h1);
`else
        readCheck("b2b_r4_a", 4'd4, 32'h0);
`endif
        idleCycle();
`ifdef WB_BYPASS_EN
        readCheck("b2b_r4_b", 4'd4, 32'h2);
`else
        readCheck("b2b_r4_b", 4'd4, 32'h1);
`endif
        idleCycle();
        readCheck("b2b_r4_final", 4'd4, 32'h2);

        // Reset while a write to r9 is pending
        applyStimulus(1'b1, 1'b0, 32'h70, 32'h99999999, 32'h0, 4'd9, 1'b1, 1'b0, 1'b0);
        idleCycle();
        checkOutput("pend_wb_valid", {31'd0, wb_valid}, 32'd1);
        #1 rst_n = 1'b0;
        retire_exp = 32'd0;
        exp_q.delete();
        #1;
        checkOutput("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("mid_rst_wb_addr", {28'd0, wb_addr}, 32'd0);
        checkOutput("mid_rst_wb_data", wb_data, 32'd0);
        checkOutput("mid_rst_retire", retire_cnt, 32'd0);
        readCheck("mid_rst_r9", 4'd9, 32'h0);
        readCheck("mid_rst_r14", 4'd14, 32'd31);
        readCheck("mid_rst_r3", 4'd3, 32'h0);
        rst_n = 1'b1;
        idleCycle();
        idleCycle();
        readCheck("post_rst_r9", 4'd9, 32'h0);
        checkOutput("post_rst_retire", retire_cnt, 32'd0);
        checkOutput("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
